// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// FSM state encoding, requester IDs, the latched request bundle and
// the counter width helper.
package mem_arb_pkg;

  // FSM state encoding (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_A = 2'd1;
  localparam logic [1:0] ST_BUSY_B = 2'd2;

  // Requester identifiers, also the polarity of the shared mux select
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // Everything captured from the winning requester at grant time
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } mem_req_t;

  // Width of the access-latency down-counter; never narrower than one bit
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant. A lone requester always
// wins; on a tie the requester that was not granted last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic reqA,
  input  logic reqB,
  input  logic lastGrant,
  output logic grantValid,
  output logic grantId
);

  // Pick the winner from the current requests and the previous grant
  always_comb begin
    grantValid = reqA | reqB;
    grantId    = REQ_A;
    if (reqA && reqB) begin
      grantId = ~lastGrant;
    end else if (reqB) begin
      grantId = REQ_B;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported 32-bit memory between instruction fetch (A)
// and load/store (B). A granted request is latched and held on the
// memory for MEM_LATENCY cycles, then a one-cycle done pulse returns
// the read data. Every access is followed by one IDLE turnaround cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        reqA,
  input  logic        reqB,
  input  logic [31:0] addrA,
  input  logic [31:0] addrB,
  input  logic [31:0] wdataA,
  input  logic [31:0] wdataB,
  input  logic        weA,
  input  logic        weB,
  output logic        doneA,
  output logic        doneB,
  output logic [31:0] rdata,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic        memWE,
  output logic        memRE,
  input  logic [31:0] memRData,
  output logic        sel
);

  localparam int               CNT_W    = cnt_width(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  // The mux select is kept apart from the tie-break history: after reset
  // the select must show A while the history says B so A wins a tie.
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_req_t         req_q, req_d;

  logic grant_valid;
  logic grant_id;
  logic busy;
  logic last_cycle;

  rr_arb2 u_rr_arb2 (
    .reqA       (reqA),
    .reqB       (reqB),
    .lastGrant  (last_grant_q),
    .grantValid (grant_valid),
    .grantId    (grant_id)
  );

  // Next-state logic: grant and latch in IDLE, count down while busy
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d      = (grant_id == REQ_B) ? ST_BUSY_B : ST_BUSY_A;
          last_grant_d = grant_id;
          sel_d        = grant_id;
          cnt_d        = CNT_LOAD;
          if (grant_id == REQ_B) begin
            req_d = '{addr: addrB, wdata: wdataB, we: weB};
          end else begin
            req_d = '{addr: addrA, wdata: wdataA, we: weA};
          end
        end
      end
      ST_BUSY_A, ST_BUSY_B: begin
        // Leave on the done cycle so the counter never wraps
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and request latches; reset abandons any access
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_B;
      sel_q        <= REQ_A;
      cnt_q        <= '0;
      req_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
    end
  end

  // Output decode: memory strobes while busy, done on the final count
  always_comb begin
    busy       = (state_q == ST_BUSY_A) || (state_q == ST_BUSY_B);
    last_cycle = busy && (cnt_q == '0);
    doneA      = last_cycle && (state_q == ST_BUSY_A);
    doneB      = last_cycle && (state_q == ST_BUSY_B);
    rdata      = (doneA || doneB) ? memRData : 32'd0;
    memAddr    = req_q.addr;
    memWData   = req_q.wdata;
    memWE      = busy && req_q.we;
    memRE      = busy && !req_q.we;
    sel        = sel_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Two instances (latency 2 and 1)
// see identical stimulus. A transaction-level model timestamps every
// grant and queues the expected access; a monitor on the falling edge
// compares the memory-side signals and the done/rdata pulse against it.
module tb_mem_port_arbiter;

  localparam int NDUT = 2;
  localparam int LAT [NDUT] = '{2, 1};

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        reqA = 1'b0, reqB = 1'b0, weA = 1'b0, weB = 1'b0;
  logic [31:0] addrA = '0, addrB = '0, wdataA = '0, wdataB = '0;

  logic        doneA [NDUT];
  logic        doneB [NDUT];
  logic        memWE [NDUT];
  logic        memRE [NDUT];
  logic        sel   [NDUT];
  logic [31:0] rdata    [NDUT];
  logic [31:0] memAddr  [NDUT];
  logic [31:0] memWData [NDUT];
  logic [31:0] memRData [NDUT];

  always #5 Clk = ~Clk;

  // Memory contents as a pure function of address
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    return (a == 32'h40) ? 32'hDEADBEEF : h;
  endfunction

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    assign memRData[gi] = mem_f(memAddr[gi]);

    mem_port_arbiter #(.MEM_LATENCY(LAT[gi])) u_dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .reqA     (reqA),
      .reqB     (reqB),
      .addrA    (addrA),
      .addrB    (addrB),
      .wdataA   (wdataA),
      .wdataB   (wdataB),
      .weA      (weA),
      .weB      (weB),
      .doneA    (doneA[gi]),
      .doneB    (doneB[gi]),
      .rdata    (rdata[gi]),
      .memAddr  (memAddr[gi]),
      .memWData (memWData[gi]),
      .memWE    (memWE[gi]),
      .memRE    (memRE[gi]),
      .memRData (memRData[gi]),
      .sel      (sel[gi])
    );
  end

  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    int          last_edge;
  } exp_t;

  exp_t        exp_q [NDUT][$];
  int          edge_cnt = 0;
  int          next_sample [NDUT];
  logic        last_win [NDUT];
  logic        sel_exp [NDUT];
  logic [31:0] held_addr [NDUT];
  logic [31:0] held_wdata [NDUT];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d (lat=%0d) t=%0t: got %08h expected %08h",
                  name, d, LAT[d], $time, act, exp);
  endtask

  // Reference model: a grant is possible once the previous access plus
  // its turnaround has elapsed; ties go to whoever did not win last.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int d = 0; d < NDUT; d++) begin
        exp_q[d].delete();
        next_sample[d] = 0;
        last_win[d]    = 1'b1;
        sel_exp[d]     = 1'b0;
        held_addr[d]   = '0;
        held_wdata[d]  = '0;
      end
    end else begin
      edge_cnt++;
      for (int d = 0; d < NDUT; d++) begin
        if (edge_cnt >= next_sample[d] && (reqA || reqB)) begin
          logic w;
          exp_t e;
          w = (reqA && reqB) ? ~last_win[d] : reqB;
          e.id        = w;
          e.addr      = w ? addrB : addrA;
          e.wdata     = w ? wdataB : wdataA;
          e.we        = w ? weB : weA;
          e.last_edge = edge_cnt + LAT[d] - 1;
          exp_q[d].push_back(e);
          next_sample[d] = edge_cnt + LAT[d] + 1;
          last_win[d]    = w;
          sel_exp[d]     = w;
          held_addr[d]   = e.addr;
          held_wdata[d]  = e.wdata;
        end
      end
    end
  end

  // Monitor: compare every cycle against the head of the expectation queue
  exp_t mon_h;
  always @(negedge Clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (!Rst_n) begin
        check("rst_strobes", d, 32'({memWE[d], memRE[d], doneA[d], doneB[d], sel[d]}), 32'd0);
        check("rst_addr", d, memAddr[d], 32'd0);
        check("rst_rdata", d, rdata[d], 32'd0);
      end else if (exp_q[d].size() > 0) begin
        mon_h = exp_q[d][0];
        check("busy_addr", d, memAddr[d], mon_h.addr);
        check("busy_wdata", d, memWData[d], mon_h.wdata);
        check("busy_we_re", d, 32'({memWE[d], memRE[d]}), 32'({mon_h.we, ~mon_h.we}));
        check("busy_sel", d, 32'(sel[d]), 32'(mon_h.id));
        if (mon_h.last_edge == edge_cnt) begin
          check("done", d, 32'({doneA[d], doneB[d]}), 32'({~mon_h.id, mon_h.id}));
          check("rdata", d, rdata[d], mem_f(mon_h.addr));
          $display("dut%0d lat=%0d edge=%0d grant=%s %s addr=%08h wdata=%08h rdata=%08h",
                   d, LAT[d], edge_cnt, mon_h.id ? "B" : "A", mon_h.we ? "WR" : "RD",
                   mon_h.addr, mon_h.wdata, rdata[d]);
          void'(exp_q[d].pop_front());
        end else begin
          check("early_done", d, 32'({doneA[d], doneB[d]}), 32'd0);
        end
      end else begin
        check("idle_strobes", d, 32'({memWE[d], memRE[d], doneA[d], doneB[d]}), 32'd0);
        check("idle_rdata", d, rdata[d], 32'd0);
        check("idle_sel", d, 32'(sel[d]), 32'(sel_exp[d]));
        check("idle_addr", d, memAddr[d], held_addr[d]);
        check("idle_wdata", d, memWData[d], held_wdata[d]);
      end
    end
  end

  task automatic drive(input logic ra, input logic rb, input logic [31:0] aa,
                       input logic [31:0] ab, input logic [31:0] da,
                       input logic [31:0] db, input logic wa, input logic wb);
    @(negedge Clk);
    #1;
    reqA = ra; reqB = rb; addrA = aa; addrB = ab;
    wdataA = da; wdataB = db; weA = wa; weB = wb;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    #2 Rst_n = 1'b1;

    // Reset during the first busy cycle of a read from A
    drive(1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge Clk);
    #1 reqA = 1'b0;
    #1 Rst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check("abort_re", d, 32'(memRE[d]), 32'd0);
      check("abort_done", d, 32'({doneA[d], doneB[d]}), 32'd0);
      check("abort_sel", d, 32'(sel[d]), 32'd0);
    end
    repeat (2) @(negedge Clk);
    #2 Rst_n = 1'b1;
    idle(2);

    // Single read from A
    drive(1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(4);

    // Single write from B, address changed while the access is in flight
    drive(1'b0, 1'b1, 32'h0, 32'h80, 32'h0, 32'h12345678, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 32'hFC, 32'h0, 32'h12345678, 1'b0, 1'b1);
    idle(4);

    // Continuous contention: grants must alternate
    repeat (14) drive(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom,
                      1'($urandom), 1'($urandom));
    idle(4);

    // A alone keeps requesting: stale request becomes a new access
    repeat (5) drive(1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0);
    idle(4);

    // Randomised traffic with one asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom));
      if (i == 200) begin
        #2 Rst_n = 1'b0;
        @(negedge Clk);
        #2 Rst_n = 1'b1;
      end
    end
    idle(6);

    for (int d = 0; d < NDUT; d++) begin
      check("drain_empty", d, 32'(exp_q[d].size()), 32'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing a single-ported 32-bit data memory between the instruction-fetch path (requester A) and the load/store path (requester B). It latches the winning request, drives the memory for a fixed access latency, and returns read data with a one-cycle done pulse. It also drives the select of the shared 2:1 32-bit address/data mux in front of the memory. It sits between the fetch/MEM-stage logic and the memory model.

## Interface
- `MEM_LATENCY`, default 2: cycles a granted access occupies the memory (≥1).
- `Clk`  in  1: single clock, rising edge.
- `Rst_n`  in  1: asynchronous, active-low reset.
- `reqA` / `reqB`  in  1: access request from requester A / B.
- `addrA` / `addrB`  in  32: byte address.
- `wdataA` / `wdataB`  in  32: write data.
- `weA` / `weB`  in  1: 1 = write, 0 = read.
- `doneA` / `doneB`  out  1: one-cycle pulse on the last access cycle.
- `rdata`  out  32: read data, valid only while `doneA` or `doneB` is high.
- `memAddr`  out  32: latched address to memory.
- `memWData`  out  32: latched write data.
- `memWE` / `memRE`  out  1: memory write / read enable.
- `memRData`  in  32: memory read data.
- `sel`  out  1: shared mux select; 0 = A, 1 = B.

## Operation
- The FSM has three states: IDLE, BUSY_A and BUSY_B.
- **IDLE:** sample `reqA`/`reqB` at each edge.
  - Exactly one request: grant it.
  - Both requests: grant the requester not granted last (`lastGrant` register).
  - On grant: latch addr/wdata/we of the winner, load `cnt` = MEM_LATENCY−1, go to BUSY_X, set `lastGrant` = X.
- **BUSY_X:**
  - `memAddr`/`memWData` come from the latches.
  - `memWE` = latched we; `memRE` = ~latched we.
  - `sel` = X.
  - `cnt` decrements each cycle.
  - When `cnt` == 0: `doneX` = 1 and `rdata` = `memRData` (combinational); the next state is IDLE.
- Latched values are held for the whole access. Changing or dropping `addrX`/`reqX` mid-access has no effect and does not abort the access.
- A requester must deassert `reqX` by the edge after `doneX`. If it is still high, IDLE treats it as a new request.
- Outputs in IDLE:
  - `memWE` = `memRE` = 0, `doneA` = `doneB` = 0, `rdata` = 0.
  - `sel` holds `lastGrant`.
  - `memAddr`/`memWData` hold their last latched values.
- **Reset (asynchronous, any state, including mid-access):**
  - state = IDLE, `lastGrant` = B (so A wins the first tie), `cnt` = 0, all latches 0.
  - All outputs are 0: `sel` = 0, `memWE` = `memRE` = 0, no done pulse.
  - An aborted access is not completed or replayed.

## Timing
- Request seen at edge t → BUSY from cycle t+1 → done in cycle t+MEM_LATENCY.
- Back-to-back throughput is one access per MEM_LATENCY+1 cycles, because of the mandatory IDLE turnaround cycle.
- With MEM_LATENCY=1, done is asserted in the single BUSY cycle.
- Under continuous contention, grants alternate strictly A, B, A, B…
- A lone requester may win consecutively.
- `doneA` and `doneB` are never high together.
- `memWE` and `memRE` are never high together.
- `cnt` width is `$clog2(MEM_LATENCY)`, minimum 1 bit. It never underflows: the FSM leaves BUSY when `cnt` reaches 0.

## Structure
- Shared package `mem_arb_pkg`: state encoding constants (IDLE=2'd0, BUSY_A=2'd1, BUSY_B=2'd2) and the requester IDs (A=1'b0, B=1'b1).
- Sub-module `rr_arb2`: combinational two-way round-robin grant.
  - Inputs: `reqA`, `reqB`, `lastGrant`.
  - Outputs: `grantValid`, `grantId`.
- The top level holds the FSM, counter and latches.

## Test plan
- **Reset mid-read:** reset, then `reqA`, `addrA`=0x100, `weA`=0, MEM_LATENCY=2. Assert `Rst_n`=0 in the first BUSY cycle → `memRE` drops immediately, no `doneA`, `sel`=0, state IDLE after release.
- **Single read:** `reqA` at edge 0, `addrA`=0x40, memory returns 0xDEADBEEF → `memRE`=1 in cycles 1–2, `doneA`=1 in cycle 2 with `rdata`=0xDEADBEEF, `sel`=0.
- **Single write:** `reqB`, `addrB`=0x80, `wdataB`=0x12345678, `weB`=1 → `sel`=1, `memWE`=1 for 2 cycles with `memAddr`=0x80 and `memWData`=0x12345678, `doneB` pulses in cycle 2, `memRE` stays 0.
- **Contention after reset:** `reqA` and `reqB` both held → grant order A, B, A, B; each done 3 cycles apart; no overlapping done pulses.
- **Mid-access input change:** change `addrB` from 0x80 to 0xFC during BUSY_B → `memAddr` stays 0x80 until done.
- **Stale request:** keep `reqA` high one cycle after `doneA` → treated as a second A access starting the next cycle. Separately, with MEM_LATENCY=1 → done appears in the cycle immediately after the grant edge.
